// File: rtl/gpu_pkg.sv
// Shared GPU definitions: scanout FSM states, VRAM 16bpp geometry and the
// 15-bit to 24-bit colour expansion used by scanout and the display DAC path.
package gpu_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      FETCH     = 2'd1,
      FULL_WAIT = 2'd2,
      DONE      = 2'd3
   } scanout_state_t;

   localparam logic [3:0] VRAM_MODE_16BPP = 4'd2;
   localparam int         VRAM_COLS_16BPP = 1024;

   // PSX pixel {m, b5, g5, r5} -> {r8, g8, b8}; the top bits are replicated
   // into the low bits so full-scale 5-bit maps to 8'hFF. Mask bit ignored.
   function automatic logic [23:0] pix15_to_rgb24(input logic [15:0] pix);
      logic [4:0] r5;
      logic [4:0] g5;
      logic [4:0] b5;
      r5 = pix[4:0];
      g5 = pix[9:5];
      b5 = pix[14:10];
      return {r5, r5[4:2], g5, g5[4:2], b5, b5[4:2]};
   endfunction

endpackage

// File: rtl/scanout_fifo.sv
// Synchronous pixel FIFO with occupancy count and flush.
// A pop frees a slot for a push in the same cycle, so push is accepted at
// full when a pop accompanies it. Flush wins over push and pop.
module scanout_fifo #(
   parameter  int DEPTH = 16,
   parameter  int WIDTH = 24,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign head    = mem[rd_ptr];

   // Storage write; contents need no reset since count gates visibility.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointer and occupancy tracking.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/vram_scanout.sv
// Display-side VRAM read initiator: walks the visible rectangle, expands
// 16bpp pixels to RGB888 and buffers them for the video timing generator.
// Optional build macro SCANOUT_STATS_EN adds underflow_cnt and lines_fetched.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | no frame since reset; waiting for frame_start
// FETCH     | requesting VRAM, one read per granted cycle if FIFO not full
// FULL_WAIT | FIFO filled; request dropped until it drains to DEPTH-4
// DONE      | whole rectangle fetched; waiting for next frame_start
module vram_scanout
   import gpu_pkg::*;
#(
   parameter int H_RES      = 320,
   parameter int V_RES      = 240,
   parameter int FIFO_DEPTH = 16
) (
   input  logic        clk_53_2MHz,
   input  logic        rst,
   input  logic        frame_start,
   input  logic [9:0]  disp_x,
   input  logic [8:0]  disp_y,
   input  logic        vram_gnt,
   input  logic [23:0] vram_data,
   output logic [8:0]  vram_line,
   output logic [11:0] vram_col,
   output logic [3:0]  vram_mode,
   output logic        vram_re,
   output logic        vram_req,
   input  logic        pix_req,
   output logic        pix_valid,
   output logic [23:0] pix_rgb,
   output logic        underflow,
   output logic        frame_busy
`ifdef SCANOUT_STATS_EN
   ,
   output logic [15:0] underflow_cnt,
   output logic [8:0]  lines_fetched
`endif
);

   localparam int                COL_W      = $clog2(VRAM_COLS_16BPP);
   localparam int                CW         = $clog2(FIFO_DEPTH) + 1;
   localparam logic [COL_W-1:0]  X_LAST     = COL_W'(H_RES - 1);
   localparam logic [8:0]        Y_LAST     = 9'(V_RES - 1);
   localparam logic [CW-1:0]     RESUME_LVL = CW'(FIFO_DEPTH - 4);

   scanout_state_t   state;
   logic [COL_W-1:0] ox;
   logic [8:0]       oy;
   logic [COL_W-1:0] x_cnt;
   logic [8:0]       y_cnt;
   logic [COL_W-1:0] col_sum;

   logic             fifo_pop;
   logic [23:0]      fifo_head;
   logic [CW-1:0]    fifo_count;
   logic             fifo_full;
   logic             fifo_empty;
   logic             unused_data_hi;

   // Address is pure arithmetic on registered origin/counters; natural
   // width overflow gives the wrap at the VRAM right and bottom edges.
   assign col_sum   = ox + x_cnt;
   assign vram_col  = 12'(col_sum);
   assign vram_line = oy + y_cnt;
   assign vram_mode = VRAM_MODE_16BPP;

   // vram_req is high exactly in FETCH, so it doubles as the state decode.
   assign vram_re  = vram_req & vram_gnt & ~fifo_full;
   // A pop coinciding with frame_start is dropped: that pixel belongs to the
   // frame being abandoned.
   assign fifo_pop = pix_req & ~fifo_empty & ~frame_start;

   assign unused_data_hi = ^vram_data[23:16];

   scanout_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (24)
   ) u_fifo (
      .clk       (clk_53_2MHz),
      .rst       (rst),
      .flush     (frame_start),
      .push      (vram_re),
      .push_data (pix15_to_rgb24(vram_data[15:0])),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Fetch sequencer: origin latch, raster counters and registered status.
   always_ff @(posedge clk_53_2MHz or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         ox         <= '0;
         oy         <= '0;
         x_cnt      <= '0;
         y_cnt      <= '0;
         vram_req   <= 1'b0;
         frame_busy <= 1'b0;
      end else if (frame_start) begin
         state      <= FETCH;
         ox         <= disp_x;
         oy         <= disp_y;
         x_cnt      <= '0;
         y_cnt      <= '0;
         vram_req   <= 1'b1;
         frame_busy <= 1'b1;
      end else begin
         case (state)
            FETCH: begin
               if (vram_re) begin
                  if (x_cnt == X_LAST) begin
                     x_cnt <= '0;
                     if (y_cnt == Y_LAST) begin
                        state      <= DONE;
                        vram_req   <= 1'b0;
                        frame_busy <= 1'b0;
                     end else begin
                        y_cnt <= y_cnt + 1'b1;
                     end
                  end else begin
                     x_cnt <= x_cnt + 1'b1;
                  end
               end else if (fifo_full) begin
                  state    <= FULL_WAIT;
                  vram_req <= 1'b0;
               end
            end
            FULL_WAIT: begin
               // Resume only with room for several reads, so the arbiter is
               // not asked for a single slot at a time.
               if (fifo_count <= RESUME_LVL) begin
                  state    <= FETCH;
                  vram_req <= 1'b1;
               end
            end
            default: begin
               state <= state;
            end
         endcase
      end
   end

   // Output stage: registered pixel, valid and underflow pulse.
   always_ff @(posedge clk_53_2MHz or posedge rst) begin
      if (rst) begin
         pix_valid <= 1'b0;
         pix_rgb   <= '0;
         underflow <= 1'b0;
      end else begin
         pix_valid <= fifo_pop;
         underflow <= pix_req & fifo_empty;
         if (fifo_pop) begin
            pix_rgb <= fifo_head;
         end
      end
   end

`ifdef SCANOUT_STATS_EN
   assign lines_fetched = y_cnt;

   // Underflow event counter, saturating, cleared per frame.
   always_ff @(posedge clk_53_2MHz or posedge rst) begin
      if (rst) begin
         underflow_cnt <= '0;
      end else if (frame_start) begin
         underflow_cnt <= '0;
      end else if (pix_req && fifo_empty && underflow_cnt != 16'hFFFF) begin
         underflow_cnt <= underflow_cnt + 1'b1;
      end
   end
`endif

endmodule
